// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - in-order instruction prefetch queue with credit-limited fetch and redirect flush
// Optional feature macro PREFETCH_BYPASS_EN: an empty queue forwards an arriving response straight to instr_*.
module instr_prefetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(DEPTH);

   logic              run;
   logic [ADDR_W-1:0] fetch_pc;

   logic [ADDR_W-1:0] fly_pc [DEPTH];
   logic [PTR_W-1:0]  fly_wr;
   logic [PTR_W-1:0]  fly_rd;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  outstanding_nxt;
   logic [CNT_W-1:0]  discard;

   logic [ADDR_W-1:0] q_pc   [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [PTR_W-1:0]  q_head;
   logic [PTR_W-1:0]  q_tail;
   logic [CNT_W-1:0]  q_count;

   logic              grant;
   logic              accept;
   logic              q_write;
   logic              pop;
   logic              q_empty;
   logic [CNT_W:0]    credit_used;

   // Queued entries and in-flight requests (including ones being discarded) share the credit pool.
   assign credit_used = {1'b0, q_count} + {1'b0, outstanding};
   assign mem_req     = run & (credit_used < CREDIT_MAX);
   assign mem_addr    = fetch_pc;
   assign grant       = mem_req & mem_gnt;
   assign q_empty     = (q_count == '0);
   assign accept      = mem_rvalid & (discard == '0) & ~redirect;
   assign pop         = ~q_empty & instr_ready & ~redirect;

`ifdef PREFETCH_BYPASS_EN
   logic bypass;

   assign bypass      = accept & q_empty;
   assign instr_valid = ~q_empty | bypass;
   assign instr       = bypass ? mem_rdata : q_data[q_head];
   assign instr_pc    = bypass ? fly_pc[fly_rd] : q_pc[q_head];
   assign q_write     = accept & ~(bypass & instr_ready);
`else
   assign instr_valid = ~q_empty;
   assign instr       = q_data[q_head];
   assign instr_pc    = q_pc[q_head];
   assign q_write     = accept;
`endif

   always_comb begin
      outstanding_nxt = outstanding;
      if (grant && !mem_rvalid) begin
         outstanding_nxt = outstanding + CNT_W'(1);
      end else if (!grant && mem_rvalid) begin
         outstanding_nxt = outstanding - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= 1'b0;
         fetch_pc    <= RESET_PC;
         fly_wr      <= '0;
         fly_rd      <= '0;
         outstanding <= '0;
         discard     <= '0;
         q_head      <= '0;
         q_tail      <= '0;
         q_count     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fly_pc[i] <= '0;
            q_pc[i]   <= '0;
            q_data[i] <= '0;
         end
      end else begin
         run         <= 1'b1;
         outstanding <= outstanding_nxt;

         // The in-flight PC FIFO tracks memory order regardless of redirects.
         if (grant) begin
            fly_pc[fly_wr] <= fetch_pc;
            fly_wr         <= fly_wr + PTR_W'(1);
         end
         if (mem_rvalid) begin
            fly_rd <= fly_rd + PTR_W'(1);
         end

         if (redirect) begin
            fetch_pc <= redirect_pc;
            discard  <= outstanding_nxt;
            q_head   <= '0;
            q_tail   <= '0;
            q_count  <= '0;
         end else begin
            if (grant) begin
               fetch_pc <= fetch_pc + ADDR_W'(2);
            end
            if (mem_rvalid && (discard != '0)) begin
               discard <= discard - CNT_W'(1);
            end
            if (q_write) begin
               q_pc[q_tail]   <= fly_pc[fly_rd];
               q_data[q_tail] <= mem_rdata;
               q_tail         <= q_tail + PTR_W'(1);
            end
            if (pop) begin
               q_head <= q_head + PTR_W'(1);
            end
            if (q_write && !pop) begin
               q_count <= q_count + CNT_W'(1);
            end else if (!q_write && pop) begin
               q_count <= q_count - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - scoreboard bench for instr_prefetch_queue
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          ADDR_W   = 16;
   localparam int          DATA_W   = 16;
   localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef PREFETCH_BYPASS_EN
   localparam int BYP_LAT = 0;
`else
   localparam int BYP_LAT = 1;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready = 1'b0;
   logic              redirect = 1'b0;
   logic [ADDR_W-1:0] redirect_pc = '0;

   instr_prefetch_queue #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } resp_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          lat = 1;
   int          gnt_pct = 0;
   int          rdy_pct = 0;
   logic [15:0] exp_pc = RESET_PC;
   logic [31:0] sb[$];
   resp_t       pend[$];
   logic [15:0] grant_log[$];
   int          n_grants = 0;
   int          n_pops = 0;
   int          last_rv_cyc = -1;
   int          first_iv_cyc = -1;
   logic [15:0] last_pop_pc = '0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic drive_ctl();
      mem_gnt     = (int'($urandom_range(99)) < gnt_pct);
      instr_ready = (int'($urandom_range(99)) < rdy_pct);
   endtask

   // One clock: observe at the falling edge, update inputs just after the rising edge.
   task automatic cycle();
      logic [31:0] exp;
      @(negedge clk);
      if (rst_n) begin
         if (instr_valid && instr_ready && !redirect) begin
            n_pops++;
            last_pop_pc = instr_pc;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected: got pc=%h instr=%h, required no instruction", instr_pc, instr);
            end else begin
               exp = sb.pop_front();
               if ({instr_pc, instr} !== exp) begin
                  failures++;
                  $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                           instr_pc, instr, exp[31:16], exp[15:0]);
               end
            end
         end
         if (mem_req && mem_gnt) begin
            checks++;
            if (mem_addr !== exp_pc) begin
               failures++;
               $display("FAIL grant_addr: got %h, required %h", mem_addr, exp_pc);
            end
            grant_log.push_back(mem_addr);
            n_grants++;
            pend.push_back('{addr: mem_addr, due: cyc + lat});
            if (!redirect) sb.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 16'd2;
         end
         if (redirect) begin
            sb.delete();
            exp_pc = redirect_pc;
         end
         if (mem_rvalid) last_rv_cyc = cyc;
         if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
      drive_ctl();
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_word(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         mem_rvalid = 1'b0;
         mem_rdata  = 16'($urandom);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_rvalid = 1'b0;
      redirect = 1'b0;
      pend.delete();
      sb.delete();
      grant_log.delete();
      exp_pc = RESET_PC;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
      drive_ctl();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b, required 0", mem_req); end
      if (mem_addr !== RESET_PC) begin failures++; $display("FAIL reset_mem_addr: got %h, required %h", mem_addr, RESET_PC); end
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %b, required 0", instr_valid); end
      if (instr !== 16'h0) begin failures++; $display("FAIL reset_instr: got %h, required 0000", instr); end
      if (instr_pc !== 16'h0) begin failures++; $display("FAIL reset_instr_pc: got %h, required 0000", instr_pc); end
      gnt_pct = 0;
      rdy_pct = 0;
      do_reset();
      cycle();
      #3;
      checks += 2;
      if (mem_req !== 1'b1) begin failures++; $display("FAIL run_mem_req: got %b, required 1", mem_req); end
      if (mem_addr !== RESET_PC) begin failures++; $display("FAIL run_mem_addr: got %h, required %h", mem_addr, RESET_PC); end
   endtask

   task automatic test_stream();
      lat = 1; gnt_pct = 100; rdy_pct = 100;
      do_reset();
      run(4);
      n_pops = 0;
      run(16);
      checks++;
      if (n_pops != 16) begin failures++; $display("FAIL stream_no_gaps: got %0d pops, required 16", n_pops); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (grant_log[i] !== 16'(2 * i)) begin
            failures++;
            $display("FAIL stream_addr%0d: got %h, required %h", i, grant_log[i], 16'(2 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      lat = 1; gnt_pct = 100; rdy_pct = 0;
      do_reset();
      n_grants = 0;
      run(15);
      #3;
      checks += 4;
      if (n_grants != DEPTH) begin failures++; $display("FAIL bp_grants: got %0d, required %0d", n_grants, DEPTH); end
      if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_mem_req: got %b, required 0", mem_req); end
      if (instr_valid !== 1'b1) begin failures++; $display("FAIL bp_instr_valid: got %b, required 1", instr_valid); end
      if (instr_pc !== RESET_PC) begin failures++; $display("FAIL bp_head_pc: got %h, required %h", instr_pc, RESET_PC); end
      rdy_pct = 100;
      drive_ctl();
      n_pops = 0;
      run(12);
      checks += 2;
      if (n_pops < DEPTH) begin failures++; $display("FAIL bp_drain: got %0d pops, required at least %0d", n_pops, DEPTH); end
      if (n_grants <= DEPTH) begin failures++; $display("FAIL bp_resume: got %0d grants, required more than %0d", n_grants, DEPTH); end
   endtask

   task automatic test_redirect();
      int guard;
      gnt_pct = 0; rdy_pct = 100;
      drive_ctl();
      run(10);
      lat = 4; gnt_pct = 100;
      drive_ctl();
      run(3);
      gnt_pct = 0;
      drive_ctl();
      redirect = 1'b1;
      redirect_pc = 16'h0100;
      run(1);
      redirect = 1'b0;
      gnt_pct = 100;
      drive_ctl();
      #3;
      checks += 2;
      if (mem_addr !== 16'h0100) begin failures++; $display("FAIL redir_addr: got %h, required 0100", mem_addr); end
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL redir_empty: got instr_valid=%b, required 0", instr_valid); end
      n_pops = 0;
      guard = 0;
      while (n_pops == 0 && guard < 40) begin cycle(); guard++; end
      checks++;
      if (n_pops == 0) begin
         failures++; $display("FAIL redir_first_pc: got no instruction within 40 cycles, required pc 0100");
      end else if (last_pop_pc !== 16'h0100) begin
         failures++; $display("FAIL redir_first_pc: got %h, required 0100", last_pop_pc);
      end
   endtask

   task automatic test_redirect_collide();
      int guard;
      lat = 2; gnt_pct = 100; rdy_pct = 100;
      drive_ctl();
      run(12);
      redirect = 1'b1;
      redirect_pc = 16'h0200;
      #3;
      checks++;
      if (!(mem_rvalid && instr_valid && instr_ready)) begin
         failures++;
         $display("FAIL collide_setup: got rvalid=%b valid=%b ready=%b, required all 1", mem_rvalid, instr_valid, instr_ready);
      end
      run(1);
      redirect = 1'b0;
      #3;
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL collide_empty: got instr_valid=%b, required 0", instr_valid); end
      n_pops = 0;
      guard = 0;
      while (n_pops == 0 && guard < 40) begin cycle(); guard++; end
      checks++;
      if (last_pop_pc !== 16'h0200 || n_pops == 0) begin
         failures++; $display("FAIL collide_first_pc: got %h (pops %0d), required 0200", last_pop_pc, n_pops);
      end
      run(10);
   endtask

   task automatic test_wrap();
      lat = 1; gnt_pct = 100; rdy_pct = 100;
      drive_ctl();
      redirect = 1'b1;
      redirect_pc = 16'hFFFC;
      run(1);
      redirect = 1'b0;
      grant_log.delete();
      run(8);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (grant_log.size() <= i) begin
            failures++; $display("FAIL wrap_addr%0d: got no grant, required %h", i, 16'(16'hFFFC + 2 * i));
         end else if (grant_log[i] !== 16'(16'hFFFC + 2 * i)) begin
            failures++; $display("FAIL wrap_addr%0d: got %h, required %h", i, grant_log[i], 16'(16'hFFFC + 2 * i));
         end
      end
   endtask

   task automatic test_bypass_latency();
      gnt_pct = 0; rdy_pct = 100;
      drive_ctl();
      run(12);
      lat = 2;
      last_rv_cyc = -1;
      first_iv_cyc = -1;
      gnt_pct = 100;
      drive_ctl();
      run(1);
      gnt_pct = 0;
      drive_ctl();
      run(8);
      checks++;
      if (last_rv_cyc < 0 || first_iv_cyc < 0 || first_iv_cyc - last_rv_cyc != BYP_LAT) begin
         failures++;
         $display("FAIL rvalid_to_valid: got rvalid cycle %0d valid cycle %0d, required distance %0d",
                  last_rv_cyc, first_iv_cyc, BYP_LAT);
      end
   endtask

   task automatic test_random();
      lat = 3; gnt_pct = 60; rdy_pct = 50;
      drive_ctl();
      for (int i = 0; i < 300; i++) begin
         if (i % 37 == 36) begin
            redirect = 1'b1;
            redirect_pc = 16'($urandom) & 16'hFFFE;
            run(1);
            redirect = 1'b0;
         end else begin
            run(1);
         end
      end
      gnt_pct = 0; rdy_pct = 100;
      drive_ctl();
      run(25);
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL random_drain: got %0d undelivered, required 0", sb.size()); end
   endtask

   task automatic test_mid_reset();
      lat = 1; gnt_pct = 100; rdy_pct = 0;
      drive_ctl();
      run(6);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (instr_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b, required 0", instr_valid); end
      if (mem_req !== 1'b0) begin failures++; $display("FAIL midrst_req: got %b, required 0", mem_req); end
      if (mem_addr !== RESET_PC) begin failures++; $display("FAIL midrst_addr: got %h, required %h", mem_addr, RESET_PC); end
      rdy_pct = 100;
      do_reset();
      run(20);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_wrap();
      test_bypass_latency();
      test_random();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion by 400000ns, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction fetch front end for the 16-bit RISC core. Issues in-order read requests to the instruction memory over a request/grant/rvalid handshake and buffers returned 16-bit instructions with their PCs in a small FIFO. The core decode stage consumes them over a valid/ready interface. A one-cycle redirect from the branch/jump logic flushes the queue and restarts fetching at a new PC.

## Interface
- DEPTH, 4, queue entries and maximum outstanding requests (power of two, ≥2)
- ADDR_W, 16, PC / memory address width
- DATA_W, 16, instruction width
- RESET_PC, 0, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- mem_req  out  1  fetch request valid
- mem_addr  out  ADDR_W  fetch byte address
- mem_gnt  in  1  request accepted this cycle (handshake = mem_req & mem_gnt)
- mem_rvalid  in  1  read data valid; one pulse per granted request, in order, ≥1 cycle after grant
- mem_rdata  in  DATA_W  read data
- instr_valid  out  1  head entry valid
- instr  out  DATA_W  head instruction
- instr_pc  out  ADDR_W  PC of head instruction
- instr_ready  in  1  core consumes head (pop = instr_valid & instr_ready)
- redirect  in  1  single-cycle flush request
- redirect_pc  in  ADDR_W  new fetch PC, sampled when redirect=1

## Operation
- Reset values: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0; queue empty, outstanding=0, discard=0.
- fetch_pc register drives mem_addr; on grant fetch_pc ← fetch_pc+2, wrapping mod 2^ADDR_W (0xFFFE → 0x0000).
- Each granted request pushes its address into an in-flight PC FIFO; the matching rvalid pops it and writes {pc, rdata} into the instruction queue.
- Credit rule: mem_req=1 only when occupancy + outstanding < DEPTH. Queue can never overflow; rvalid is always accepted (no backpressure to memory).
- Outstanding counter: +1 on grant, −1 on rvalid, both same cycle → unchanged. Width clog2(DEPTH+1).
- mem_addr is sampled by memory only on grant; an ungranted request may be retargeted or dropped.
- Redirect (highest priority):
  - queue cleared, any same-cycle pop or push ignored;
  - fetch_pc ← redirect_pc; un-granted request retargets next cycle;
  - discard ← outstanding after this cycle's grant/rvalid accounting; subsequent rvalids decrement discard and are dropped while discard>0;
  - while discard>0, in-flight requests still consume credit.
- Redirect with discard already nonzero: discard recomputed as above (stale + new in-flight both dropped).
- Push and pop in the same cycle on a full queue legal; occupancy unchanged.

## Timing
- mem_req asserts in the first cycle after rst_n deassertion (registered run flag).
- Steady state with mem_gnt=1 and memory latency L: one request per cycle; instruction appears on instr_valid L+1 cycles after grant (see Configuration).
- Redirect at edge N: mem_addr=redirect_pc and instr_valid=0 in cycle N+1.
- rst_n assertion mid-operation: all state cleared immediately; responses arriving after reset release are not expected (memory resets with the core).

## Configuration
- PREFETCH_BYPASS_EN defined: when queue empty and a non-discarded rvalid arrives, instr/instr_pc/instr_valid present it combinationally in the same cycle; if instr_ready=1 it is consumed without being written. Latency rvalid→instr_valid = 0 cycles.
- Undefined: all outputs are taken from queue registers; latency rvalid→instr_valid = 1 cycle; no combinational path from mem_* to instr_*.

## Test plan
- Reset release, mem_gnt=1, latency 1, instr_ready=1 → addresses 0x0000,0x0002,0x0004… one per cycle; instr_pc sequence matches, no gaps after fill.
- instr_ready=0 indefinitely, DEPTH=4 → exactly 4 grants, mem_req drops, 4 entries held; raising instr_ready drains in order then fetch resumes.
- Redirect to 0x0100 with 3 requests outstanding → next 3 rvalids dropped, first delivered instr_pc=0x0100, queue empty in cycle after redirect.
- Redirect same cycle as rvalid and pop → response dropped, popped entry not re-presented, discard count correct.
- fetch_pc=0xFFFC, gnt=1 → addresses 0xFFFC,0xFFFE,0x0000.
- With/without PREFETCH_BYPASS_EN, empty queue, single rvalid at cycle T → instr_valid at T vs T+1.
